// File: rtl/hash_batch_serializer_pkg.sv
// Shared widths, batch record layout and FSM encoding for hash_batch_serializer.
// The width macros below form the parameters.vh set; a project-wide parameters.vh may predefine them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 4
`endif
`ifndef META_MATCH_LEN_WIDTH
`define META_MATCH_LEN_WIDTH 6
`endif
// Derived widths: lane index and one packed batch (head, lanes, delim).
`ifndef LANE_IDX_WIDTH
`define LANE_IDX_WIDTH $clog2(`HASH_ISSUE_WIDTH)
`endif
`ifndef BATCH_WIDTH
`define BATCH_WIDTH (`ADDR_WIDTH + `HASH_ISSUE_WIDTH*(`ADDR_WIDTH + `META_MATCH_LEN_WIDTH + 2) + 1)
`endif

package hash_batch_serializer_pkg;
    localparam int ADDR_W     = `ADDR_WIDTH;
    localparam int HIW        = `HASH_ISSUE_WIDTH;
    localparam int MLW        = `META_MATCH_LEN_WIDTH;
    localparam int LANE_IDX_W = `LANE_IDX_WIDTH;
    localparam int BATCH_W    = `BATCH_WIDTH;

    typedef struct packed {
        logic                         delim;
        logic [HIW-1:0]               can_ext;
        logic [HIW-1:0][MLW-1:0]      len;
        logic [HIW-1:0][ADDR_W-1:0]   addr;
        logic [HIW-1:0]               valid;
        logic [ADDR_W-1:0]            head;
    } batch_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_EMIT  = 1'b1
    } ser_state_t;
endpackage

// File: rtl/hash_batch_serializer_fifo.sv
// batch_fifo: single-clock FIFO with full/empty flags; a full FIFO refuses a push
// even if a pop happens in the same cycle.
module batch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/hash_batch_serializer.sv
// Buffers hash candidate batches and serialises them one lane per beat, lowest lane first.
// Optional perf counters are enabled with HASH_BATCH_SER_PERF_EN.
module hash_batch_serializer
    import hash_batch_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_head_addr,
    input  logic [HIW-1:0]        i_history_valid,
    input  logic [HIW*ADDR_W-1:0] i_history_addr,
    input  logic [HIW*MLW-1:0]    i_meta_match_len,
    input  logic [HIW-1:0]        i_meta_match_can_ext,
    input  logic                  i_delim,
    output logic                  i_ready,
    output logic                  o_valid,
    output logic                  o_cand,
    output logic [ADDR_W-1:0]     o_head_addr,
    output logic [ADDR_W-1:0]     o_history_addr,
    output logic [MLW-1:0]        o_meta_match_len,
    output logic                  o_meta_match_can_ext,
    output logic                  o_last,
    output logic                  o_delim,
`ifdef HASH_BATCH_SER_PERF_EN
    output logic [31:0]           o_perf_batch_cnt,
    output logic [31:0]           o_perf_cand_cnt,
`endif
    input  logic                  o_ready
);
    function automatic logic [LANE_IDX_W-1:0] lowest_set(input logic [HIW-1:0] m);
        lowest_set = '0;
        for (int i = HIW - 1; i >= 0; i--)
            if (m[i]) lowest_set = LANE_IDX_W'(i);
    endfunction

    batch_t     in_batch, fifo_head, work;
    ser_state_t state, state_nxt;
    logic [BATCH_W-1:0]    fifo_dout;
    logic                  fifo_full, fifo_empty, push, take, head_live;
    logic                  hs, beat_last, last_hs;
    logic [LANE_IDX_W-1:0] sel;
    logic [HIW-1:0]        rest;

    assign in_batch.delim   = i_delim;
    assign in_batch.can_ext = i_meta_match_can_ext;
    assign in_batch.len     = i_meta_match_len;
    assign in_batch.addr    = i_history_addr;
    assign in_batch.valid   = i_history_valid;
    assign in_batch.head    = i_head_addr;

    assign i_ready = !fifo_full;
    assign push    = i_valid && !fifo_full;

    batch_fifo #(.WIDTH(BATCH_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_batch),
        .pop   (take),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    assign fifo_head = fifo_dout;

    assign sel       = lowest_set(work.valid);
    assign rest      = work.valid & ~(HIW'(1) << sel);
    assign beat_last = (rest == '0);
    assign o_valid   = (state == ST_EMIT);
    assign hs        = o_valid && o_ready;
    assign last_hs   = hs && beat_last;
    // A candidate-free batch without delim carries nothing: popped but never emitted.
    assign head_live = (|fifo_head.valid) || fifo_head.delim;
    assign take      = ((state == ST_EMPTY) || last_hs) && !fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (take && head_live) state_nxt = ST_EMIT;
            ST_EMIT:  if (last_hs) state_nxt = (take && head_live) ? ST_EMIT : ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
            work  <= '0;
        end else begin
            state <= state_nxt;
            if (take)    work       <= fifo_head;
            else if (hs) work.valid <= rest;
        end
    end

    // Payload is a pure function of the working register, so it holds while stalled.
    assign o_cand               = o_valid && (|work.valid);
    assign o_head_addr          = o_valid ? work.head + ADDR_W'(sel) : '0;
    assign o_history_addr       = o_valid ? work.addr[sel] : '0;
    assign o_meta_match_len     = o_valid ? work.len[sel] : '0;
    assign o_meta_match_can_ext = o_valid && work.can_ext[sel];
    assign o_last               = o_valid && beat_last;
    assign o_delim              = o_valid && beat_last && work.delim;

`ifdef HASH_BATCH_SER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_batch_cnt <= '0;
            o_perf_cand_cnt  <= '0;
        end else begin
            if (push)          o_perf_batch_cnt <= o_perf_batch_cnt + 32'd1;
            if (hs && o_cand)  o_perf_cand_cnt  <= o_perf_cand_cnt + 32'd1;
        end
    end
`else
    // No perf counters in this build.
`endif
endmodule

// File: tb/tb_hash_batch_serializer.sv
// Directed self-checking bench for hash_batch_serializer (HIW=4, ADDR_WIDTH=16, FIFO_DEPTH=4).
module tb_hash_batch_serializer;
    import hash_batch_serializer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_valid;
    logic [ADDR_W-1:0]     i_head_addr;
    logic [HIW-1:0]        i_history_valid;
    logic [HIW*ADDR_W-1:0] i_history_addr;
    logic [HIW*MLW-1:0]    i_meta_match_len;
    logic [HIW-1:0]        i_meta_match_can_ext;
    logic                  i_delim;
    logic                  i_ready;
    logic                  o_valid, o_cand, o_meta_match_can_ext, o_last, o_delim, o_ready;
    logic [ADDR_W-1:0]     o_head_addr, o_history_addr;
    logic [MLW-1:0]        o_meta_match_len;
`ifdef HASH_BATCH_SER_PERF_EN
    logic [31:0]           o_perf_batch_cnt, o_perf_cand_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hash_batch_serializer #(.FIFO_DEPTH(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_valid              (i_valid),
        .i_head_addr          (i_head_addr),
        .i_history_valid      (i_history_valid),
        .i_history_addr       (i_history_addr),
        .i_meta_match_len     (i_meta_match_len),
        .i_meta_match_can_ext (i_meta_match_can_ext),
        .i_delim              (i_delim),
        .i_ready              (i_ready),
        .o_valid              (o_valid),
        .o_cand               (o_cand),
        .o_head_addr          (o_head_addr),
        .o_history_addr       (o_history_addr),
        .o_meta_match_len     (o_meta_match_len),
        .o_meta_match_can_ext (o_meta_match_can_ext),
        .o_last               (o_last),
        .o_delim              (o_delim),
`ifdef HASH_BATCH_SER_PERF_EN
        .o_perf_batch_cnt     (o_perf_batch_cnt),
        .o_perf_cand_cnt      (o_perf_cand_cnt),
`endif
        .o_ready              (o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] h, input logic [3:0] v, input logic d);
        i_valid         = 1'b1;
        i_head_addr     = h;
        i_history_valid = v;
        i_delim         = d;
    endtask

    // Lane k carries history 0xA000 + k*0x0111, match length 10+k, can_ext = k odd.
    task automatic check_beat(input string tag, input logic [15:0] h, input int lane,
                              input logic last, input logic delim);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_cand"},  32'(o_cand), 32'd1);
        chk({tag, "_head"},  32'(o_head_addr), 32'(h));
        chk({tag, "_hist"},  32'(o_history_addr), 32'(16'hA000 + 16'(lane) * 16'h0111));
        chk({tag, "_len"},   32'(o_meta_match_len), 32'(10 + lane));
        chk({tag, "_ext"},   32'(o_meta_match_can_ext), 32'(lane % 2));
        chk({tag, "_last"},  32'(o_last), 32'(last));
        chk({tag, "_delim"}, 32'(o_delim), 32'(delim));
    endtask

    initial begin
        int n, acc_seen, k;
        logic took;

        for (int i = 0; i < HIW; i++) begin
            i_history_addr[i*ADDR_W +: ADDR_W] = 16'hA000 + 16'(i) * 16'h0111;
            i_meta_match_len[i*MLW +: MLW]     = MLW'(10 + i);
        end
        i_meta_match_can_ext = 4'b1010;
        i_valid = 1'b0; i_head_addr = '0; i_history_valid = '0; i_delim = 1'b0;
        o_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        // Reset state
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_cand",  32'(o_cand), 32'd0);
        chk("rst_o_last",  32'(o_last), 32'd0);
        chk("rst_o_delim", 32'(o_delim), 32'd0);
        chk("rst_o_head",  32'(o_head_addr), 32'd0);
        chk("rst_o_hist",  32'(o_history_addr), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_i_ready", 32'(i_ready), 32'd1);
        chk("rst_idle_valid", 32'(o_valid), 32'd0);

        // Sparse lanes: push at E, beat visible after E+1
        drive(16'h0100, 4'b1010, 1'b0);
        tick();
        i_valid = 1'b0;
        chk("sparse_lat_e", 32'(o_valid), 32'd0);
        tick();
        check_beat("sparse_b0", 16'h0101, 1, 1'b0, 1'b0);
        tick();
        check_beat("sparse_b1", 16'h0103, 3, 1'b1, 1'b0);
        tick();
        chk("sparse_done", 32'(o_valid), 32'd0);

        // Empty batch with delim -> single marker beat
        drive(16'h0200, 4'b0000, 1'b1);
        tick();
        i_valid = 1'b0;
        tick();
        chk("delim_valid", 32'(o_valid), 32'd1);
        chk("delim_cand",  32'(o_cand), 32'd0);
        chk("delim_last",  32'(o_last), 32'd1);
        chk("delim_delim", 32'(o_delim), 32'd1);
        chk("delim_head",  32'(o_head_addr), 32'h0200);
        tick();
        chk("delim_done", 32'(o_valid), 32'd0);

        // Empty batch without delim -> discarded
        drive(16'h0200, 4'b0000, 1'b0);
        tick();
        i_valid = 1'b0;
        tick();
        chk("discard_v0", 32'(o_valid), 32'd0);
        tick();
        chk("discard_v1", 32'(o_valid), 32'd0);
        chk("discard_rdy", 32'(i_ready), 32'd1);

        // Stall: 1 batch in the working register + 4 in the FIFO = 5 accepted
        o_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (n < 6) drive(16'h1000 + 16'(n) * 16'h0010, 4'b0011, 1'b0);
            else i_valid = 1'b0;
            took = i_valid && i_ready;
            tick();
            if (took) n++;
            if (c == 3) check_beat("stall_mid", 16'h1000, 0, 1'b0, 1'b0);
        end
        i_valid = 1'b0;
        acc_seen = n;
        chk("stall_accepted", 32'(acc_seen), 32'd5);
        chk("stall_i_ready", 32'(i_ready), 32'd0);
        check_beat("stall_end", 16'h1000, 0, 1'b0, 1'b0);

        // Release: 5 batches x 2 beats in order
        o_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            if (o_valid && k < 10) begin
                chk("drain_head", 32'(o_head_addr), 32'(16'h1000 + 16'(k / 2) * 16'h0010 + 16'(k % 2)));
                chk("drain_last", 32'(o_last), 32'(k % 2));
                k++;
            end
            tick();
        end
        chk("drain_count", 32'(k), 32'd10);
        chk("drain_idle", 32'(o_valid), 32'd0);

        // Back-to-back full batches: 12 beats without a bubble
        drive(16'h3000, 4'b1111, 1'b0);
        tick();
        drive(16'h3010, 4'b1111, 1'b0);
        tick();
        check_beat("b2b_0", 16'h3000, 0, 1'b0, 1'b0);
        drive(16'h3020, 4'b1111, 1'b0);
        tick();
        i_valid = 1'b0;
        for (int b = 1; b < 12; b++) begin
            chk("b2b_valid", 32'(o_valid), 32'd1);
            chk("b2b_head", 32'(o_head_addr), 32'(16'h3000 + 16'(b / 4) * 16'h0010 + 16'(b % 4)));
            chk("b2b_last", 32'(o_last), 32'((b % 4) == 3));
            tick();
        end
        chk("b2b_done", 32'(o_valid), 32'd0);

        // Reset mid-batch after the first of three beats
        drive(16'h4000, 4'b0111, 1'b0);
        tick();
        i_valid = 1'b0;
        tick();
        check_beat("rstmid_b0", 16'h4000, 0, 1'b0, 1'b0);
        tick();
        check_beat("rstmid_b1", 16'h4001, 1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(o_valid), 32'd0);
        chk("rstmid_head", 32'(o_head_addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_stale0", 32'(o_valid), 32'd0);
        tick();
        chk("rstmid_stale1", 32'(o_valid), 32'd0);
        chk("rstmid_ready", 32'(i_ready), 32'd1);
        drive(16'h5000, 4'b0100, 1'b0);
        tick();
        i_valid = 1'b0;
        tick();
        check_beat("rstmid_next", 16'h5002, 2, 1'b1, 1'b0);
        tick();
        chk("rstmid_next_done", 32'(o_valid), 32'd0);

        // Head wrap-around, fresh counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(16'hFFFE, 4'b1000, 1'b0);
        tick();
        i_valid = 1'b0;
        tick();
        check_beat("wrap", 16'h0001, 3, 1'b1, 1'b0);
        tick();
        chk("wrap_done", 32'(o_valid), 32'd0);
`ifdef HASH_BATCH_SER_PERF_EN
        chk("perf_batch", o_perf_batch_cnt, 32'd1);
        chk("perf_cand", o_perf_cand_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
